arbiter_fifo: RTL

//  Synchronous FIFO downstream of the writer arbiter. Captures each byte the

---
 rtl/arbiter_fifo_pkg.sv | 20 ++
 rtl/arbiter_fifo_mem.sv | 38 +++
 rtl/arbiter_fifo.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/arbiter_fifo_pkg.sv
// Shared definitions for the arbiter write FIFO.
// Data bus width common with the arbiter and a constant log2 helper.
package arbiter_fifo_pkg;

    localparam int DATA_WIDTH = 8;

    // Address bits needed to index 'value' entries (value >= 2).
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/arbiter_fifo_mem.sv
// Simple dual-port storage for the arbiter FIFO.
// One write port and one registered read port; the array is never reset.
module arbiter_fifo_mem
    import arbiter_fifo_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Store accepted writes; contents survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read; holds the last popped entry between reads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/arbiter_fifo.sv
// Synchronous FIFO between the writer arbiter and a single reader.
// Count-based full/empty flags, one-cycle registered read, sticky errors.
module arbiter_fifo
    import arbiter_fifo_pkg::*;
#(
    parameter int WIDTH       = DATA_WIDTH,
    parameter int DEPTH       = 16,
    parameter int AFULL_LEVEL = 12,
    localparam int AW         = clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_we,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_full,
    output logic             o_afull,
    input  logic             i_re,
    output logic [WIDTH-1:0] o_data,
    output logic             o_rvalid,
    output logic             o_empty,
    output logic [AW:0]      o_count,
    output logic             o_overflow,
    output logic             o_underflow
);

    localparam logic [AW:0] FULL_CNT  = DEPTH[AW:0];
    localparam logic [AW:0] AFULL_CNT = AFULL_LEVEL[AW:0];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_next;
    logic          full_q;
    logic          afull_q;
    logic          empty_q;
    logic          rvalid_q;
    logic          overflow_q;
    logic          underflow_q;
    logic          wr_ok;
    logic          rd_ok;

    // Acceptance uses the registered flags only; a same-cycle pop
    // does not make room for a write into a full FIFO.
    always_comb begin
        wr_ok      = i_we & ~full_q;
        rd_ok      = i_re & ~empty_q;
        count_next = count
                   + {{AW{1'b0}}, wr_ok}
                   - {{AW{1'b0}}, rd_ok};
    end

    // Pointers wrap naturally at AW bits; occupancy kept separately.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
        end
    end

    // Status flags registered from the next occupancy.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            full_q  <= 1'b0;
            afull_q <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            full_q  <= (count_next == FULL_CNT);
            afull_q <= (count_next >= AFULL_CNT);
            empty_q <= (count_next == '0);
        end
    end

    // Read-valid pulse one cycle after an accepted pop.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= rd_ok;
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (i_we & full_q) begin
                overflow_q <= 1'b1;
            end
            if (i_re & empty_q) begin
                underflow_q <= 1'b1;
            end
        end
    end

    arbiter_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (i_clk),
        .reset (i_reset),
        .we    (wr_ok),
        .waddr (wr_ptr),
        .wdata (i_data),
        .re    (rd_ok),
        .raddr (rd_ptr),
        .rdata (o_data)
    );

    assign o_full      = full_q;
    assign o_afull     = afull_q;
    assign o_empty     = empty_q;
    assign o_rvalid    = rvalid_q;
    assign o_count     = count;
    assign o_overflow  = overflow_q;
    assign o_underflow = underflow_q;

`ifdef FORMAL
    logic f_past_valid;

    // Marks that at least one clean clock has elapsed since reset.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            f_past_valid <= 1'b0;
        end else begin
            f_past_valid <= 1'b1;
        end
    end

    // Structural invariants between count, flags and pointers.
    always_comb begin
        if (!i_reset) begin
            assert (count <= FULL_CNT);
            assert (full_q == (count == FULL_CNT));
            assert (empty_q == (count == '0));
            assert (!(full_q && empty_q));
            assert ((wr_ptr - rd_ptr) == count[AW-1:0]);
        end
    end

    // Reachability of both occupancy extremes.
    always_comb begin
        cover (f_past_valid && full_q);
        cover (f_past_valid && empty_q && o_rvalid);
    end
`endif

endmodule
